// File: rtl/acq_pkg.sv
// Shared types and default sizing for the acquisition scheduler.
package acq_pkg;

  localparam int unsigned ACQ_PERIOD_W    = 16;
  localparam int unsigned ACQ_BURST_W     = 16;
  localparam int unsigned ACQ_ACK_TIMEOUT = 1023;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_RUN  = 2'd2,
    ST_REQ  = 2'd3
  } acq_state_e;

endpackage

// File: rtl/acq_period_div.sv
// Tick divider: counts timer ticks and flags the tick that completes a period.
// The expire output is combinational so the scheduler can act on the same edge.
module acq_period_div
  import acq_pkg::*;
#(
  parameter int unsigned PERIOD_W = ACQ_PERIOD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                tick,
  input  logic [PERIOD_W-1:0] period,
  output logic                expire
);

  logic [PERIOD_W-1:0] tick_cnt;
  logic                last_c;

  // period is already normalised to be nonzero by the scheduler
  assign last_c = (tick_cnt == PERIOD_W'(period - PERIOD_W'(1)));
  assign expire = tick & ~clr & last_c;

  // Tick counter, restarted at each period boundary and held clear while idle
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= last_c ? '0 : PERIOD_W'(tick_cnt + PERIOD_W'(1));
    end
  end

endmodule

// File: rtl/acq_scheduler.sv
// Periodic acquisition scheduler: owns timer clr/ena, divides the timer tick
// by a programmable period and issues timestamped req/ack acquisitions.
// Optional ack timeout is built when ACQ_SCHED_ACK_TIMEOUT_EN is defined.
module acq_scheduler
  import acq_pkg::*;
#(
  parameter int unsigned PERIOD_W    = ACQ_PERIOD_W,
  parameter int unsigned BURST_W     = ACQ_BURST_W,
  parameter int unsigned ACK_TIMEOUT = ACQ_ACK_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [PERIOD_W-1:0] period,
  input  logic [BURST_W-1:0]  burst,
  input  logic                tick,
  input  logic [31:0]         tmr_count,
  output logic                tmr_clr,
  output logic                tmr_ena,
  output logic                acq_req,
  input  logic                acq_ack,
  output logic [31:0]         acq_ts,
  output logic [BURST_W-1:0]  req_cnt,
  output logic                busy,
  output logic                done,
  output logic                overrun,
  output logic                ack_tmo
);

  acq_state_e          state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [BURST_W-1:0]  req_cnt_d, req_cnt_inc_c;
  logic [31:0]         acq_ts_d;
  logic                acq_req_d, overrun_d, done_d;
  logic                busy_d, tmr_clr_d, tmr_ena_d;
  logic                start_ok_c, div_clr_c, expire, tmo_hit_c;

  if (ACK_TIMEOUT == 0) begin : g_bad_cfg
    $error("acq_scheduler: ACK_TIMEOUT must be nonzero");
  end

  assign start_ok_c    = (state_q == ST_IDLE) && start && !stop;
  assign div_clr_c     = (state_q == ST_IDLE) || (state_q == ST_CLR);
  assign req_cnt_inc_c = BURST_W'(req_cnt + BURST_W'(1));

  acq_period_div #(
    .PERIOD_W (PERIOD_W)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .clr    (div_clr_c),
    .tick   (tick),
    .period (period_q),
    .expire (expire)
  );

`ifdef ACQ_SCHED_ACK_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit_c = (state_q == ST_REQ) && (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));

  // Cycles spent waiting in REQ; zero on every entry to REQ
  always_ff @(posedge clk) begin
    if (rst || state_q != ST_REQ) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= TMO_W'(tmo_cnt + TMO_W'(1));
    end
  end

  // Sticky timeout flag, cleared by an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_tmo <= 1'b0;
    end else if (start_ok_c) begin
      ack_tmo <= 1'b0;
    end else if (tmo_hit_c && !stop && !acq_ack) begin
      ack_tmo <= 1'b1;
    end
  end
`else
  assign tmo_hit_c = 1'b0;
  assign ack_tmo   = 1'b0;
`endif

  // Next-state and next-output decode
  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    burst_d   = burst_q;
    acq_req_d = acq_req;
    acq_ts_d  = acq_ts;
    req_cnt_d = req_cnt;
    overrun_d = overrun;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_ok_c) begin
          period_d  = (period == '0) ? PERIOD_W'(1) : period;
          burst_d   = burst;
          req_cnt_d = '0;
          overrun_d = 1'b0;
          state_d   = ST_CLR;
        end
      end
      ST_CLR: begin
        state_d = stop ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (expire) begin
          acq_req_d = 1'b1;
          acq_ts_d  = tmr_count;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (stop) begin
          acq_req_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          // a period that ends while a request is outstanding is dropped
          if (expire) begin
            overrun_d = 1'b1;
          end
          if (acq_ack) begin
            acq_req_d = 1'b0;
            req_cnt_d = req_cnt_inc_c;
            if ((burst_q != '0) && (req_cnt_inc_c == burst_q)) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_RUN;
            end
          end else if (tmo_hit_c) begin
            acq_req_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d    = (state_d != ST_IDLE);
    tmr_clr_d = (state_d == ST_CLR);
    tmr_ena_d = (state_d == ST_RUN) || (state_d == ST_REQ);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      burst_q  <= '0;
      acq_req  <= 1'b0;
      acq_ts   <= '0;
      req_cnt  <= '0;
      overrun  <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      tmr_clr  <= 1'b0;
      tmr_ena  <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      burst_q  <= burst_d;
      acq_req  <= acq_req_d;
      acq_ts   <= acq_ts_d;
      req_cnt  <= req_cnt_d;
      overrun  <= overrun_d;
      done     <= done_d;
      busy     <= busy_d;
      tmr_clr  <= tmr_clr_d;
      tmr_ena  <= tmr_ena_d;
    end
  end

endmodule
